// File: rtl/led_fifo_tx_if.sv
// Handshake bundle between the LED frame transmitter and its pixel FIFO and controller.
// The master modport belongs to the transmitter; the slave modport belongs to the FIFO/controller side.
interface led_fifo_tx_if;
    logic        send_start;
    logic        fifo_empty;
    logic [11:0] fifo_rdata;
    logic        fifo_rd;
    logic        led_dout;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    modport master (
        input  send_start, fifo_empty, fifo_rdata,
        output fifo_rd, led_dout, busy, frame_done, underrun
    );

    modport slave (
        output send_start, fifo_empty, fifo_rdata,
        input  fifo_rd, led_dout, busy, frame_done, underrun
    );
endinterface

// File: rtl/led_fifo_tx.sv
// Serialises LED_NUM 12-bit RGB words from a FIFO onto a one-wire LED line; the line rises 3 cycles after start.
// There is no backpressure: an empty FIFO never stalls the line, the missing LED is sent as black and underrun is flagged.
module led_fifo_tx #(
    parameter int LED_NUM = 47,
    parameter int T0H     = 20,
    parameter int T0L     = 43,
    parameter int T1H     = 40,
    parameter int T1L     = 23,
    parameter int TRST    = 2500
) (
    input  logic           clk,
    input  logic           rstn,
    led_fifo_tx_if.master  tx
);
    localparam int TBIT = (T0H + T0L > T1H + T1L) ? (T0H + T0L) : (T1H + T1L);
    localparam int TMAX = (TRST > TBIT) ? TRST : TBIT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int LW   = $clog2(LED_NUM + 1);

    localparam logic [TW-1:0] T0H_END  = TW'(T0H - 1);
    localparam logic [TW-1:0] T0L_END  = TW'(T0L - 1);
    localparam logic [TW-1:0] T1H_END  = TW'(T1H - 1);
    localparam logic [TW-1:0] T1L_END  = TW'(T1L - 1);
    localparam logic [TW-1:0] TRST_END = TW'(TRST - 1);
    localparam logic [LW-1:0] LED_LAST = LW'(LED_NUM - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, BIT_H, BIT_L, LATCH} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [LW-1:0] led_cnt;
    logic [4:0]    bit_cnt;
    logic [23:0]   shift_reg;
    logic [23:0]   pref;
    logic          miss;
    logic          pf_pend;
    logic          dout_r;
    logic          busy_r;
    logic          done_r;
    logic          under_r;

    logic          pf_slot;
    logic          rd;
    logic          cur_bit;
    logic [TW-1:0] hi_end;
    logic [TW-1:0] lo_end;

    // Channels widen by nibble replication and go out in GRB order, MSB first.
    function automatic logic [23:0] expand(input logic [11:0] w);
        return {w[7:4], w[7:4], w[11:8], w[11:8], w[3:0], w[3:0]};
    endfunction

    // The next LED's word is fetched during the first high cycle of the current LED,
    // so it is ready long before the last bit ends and LEDs run back to back.
    assign pf_slot = (state == BIT_H) && (bit_cnt == 5'd0) && (timer == '0) && (led_cnt != LED_LAST);
    assign rd      = ((state == FETCH) || pf_slot) && !tx.fifo_empty;
    assign cur_bit = shift_reg[23];
    assign hi_end  = cur_bit ? T1H_END : T0H_END;
    assign lo_end  = cur_bit ? T1L_END : T0L_END;

    assign tx.fifo_rd    = rd;
    assign tx.led_dout   = dout_r;
    assign tx.busy       = busy_r;
    assign tx.frame_done = done_r;
    assign tx.underrun   = under_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            timer     <= '0;
            led_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            pref      <= '0;
            miss      <= 1'b0;
            pf_pend   <= 1'b0;
            dout_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            under_r   <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            pf_pend <= pf_slot && !tx.fifo_empty;
            if (pf_pend) begin
                pref <= expand(tx.fifo_rdata);
            end
            if (pf_slot && tx.fifo_empty) begin
                pref    <= '0;
                under_r <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tx.send_start) begin
                        state   <= FETCH;
                        busy_r  <= 1'b1;
                        led_cnt <= '0;
                        under_r <= 1'b0;
                    end
                end
                FETCH: begin
                    miss  <= tx.fifo_empty;
                    if (tx.fifo_empty) begin
                        under_r <= 1'b1;
                    end
                    state <= LOAD;
                end
                LOAD: begin
                    shift_reg <= miss ? 24'h000000 : expand(tx.fifo_rdata);
                    bit_cnt   <= 5'd0;
                    timer     <= '0;
                    dout_r    <= 1'b1;
                    state     <= BIT_H;
                end
                BIT_H: begin
                    if (timer == hi_end) begin
                        timer  <= '0;
                        dout_r <= 1'b0;
                        state  <= BIT_L;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BIT_L: begin
                    if (timer == lo_end) begin
                        timer <= '0;
                        if (bit_cnt == 5'd23) begin
                            if (led_cnt != LED_LAST) begin
                                shift_reg <= pref;
                                led_cnt   <= led_cnt + 1'b1;
                                bit_cnt   <= 5'd0;
                                dout_r    <= 1'b1;
                                state     <= BIT_H;
                            end else begin
                                state <= LATCH;
                            end
                        end else begin
                            shift_reg <= {shift_reg[22:0], 1'b0};
                            bit_cnt   <= bit_cnt + 5'd1;
                            dout_r    <= 1'b1;
                            state     <= BIT_H;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LATCH: begin
                    if (timer == TRST_END) begin
                        timer  <= '0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_fifo_tx.sv
// Directed frames are queued as expected bit timings and frame summaries; a line monitor
// decodes led_dout pulse widths and the FIFO/status signals and compares against those queues.
module tb_led_fifo_tx;
    localparam int LED_NUM = 2;
    localparam int T0H     = 2;
    localparam int T0L     = 4;
    localparam int T1H     = 4;
    localparam int T1L     = 2;
    localparam int TRST    = 10;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    led_fifo_tx_if bus();

    led_fifo_tx #(
        .LED_NUM(LED_NUM), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .TRST(TRST)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .tx  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic val;
        int   hi;
        int   lo;
    } bit_exp_t;

    typedef struct {
        int   rd;
        logic und;
    } frame_exp_t;

    bit_exp_t   bexp[$];
    frame_exp_t fexp[$];
    int         start_q[$];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic quiet = 1'b0;
    logic done_req = 1'b0;
    logic done_ack = 1'b0;

    logic [11:0] ld_w[4];
    int          ld_n = 0;
    int          ld_gen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // External FIFO: data appears the cycle after a read strobe; contents replaced on each load request.
    initial begin
        logic [11:0] fq[$];
        logic        rs;
        int          seen;
        seen           = 0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        forever begin
            @(negedge clk);
            rs = bus.fifo_rd;
            @(posedge clk);
            #1;
            if (rs && fq.size() > 0) bus.fifo_rdata = fq.pop_front();
            if (ld_gen != seen) begin
                fq.delete();
                for (int i = 0; i < ld_n; i++) fq.push_back(ld_w[i]);
                seen = ld_gen;
            end
            bus.fifo_empty = (fq.size() == 0);
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    logic prev_d = 1'b0;
    logic have_hi = 1'b0;
    logic busy_q = 1'b0;
    int   hi = 0;
    int   lo = 0;
    int   rd_cnt = 0;
    int   busy_len = 0;

    task automatic finish_bit(input logic last);
        bit_exp_t e;
        if (quiet) return;
        check("bit_expected", int'(bexp.size() > 0), 1);
        if (bexp.size() > 0) begin
            e = bexp.pop_front();
            check("bit_high", hi, e.hi);
            check("bit_low", lo, last ? e.lo + TRST : e.lo);
        end
    endtask

    always @(negedge clk) begin
        frame_exp_t f;
        if (!rstn) begin
            check("rst_led_dout", int'(bus.led_dout), 0);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_frame_done", int'(bus.frame_done), 0);
            check("rst_fifo_rd", int'(bus.fifo_rd), 0);
            check("rst_underrun", int'(bus.underrun), 0);
            prev_d   = 1'b0;
            have_hi  = 1'b0;
            busy_q   = 1'b0;
            hi       = 0;
            lo       = 0;
            rd_cnt   = 0;
            busy_len = 0;
        end else begin
            if (bus.busy && !busy_q) rd_cnt = 0;
            if (bus.fifo_rd) begin
                rd_cnt++;
                check("rd_while_empty", int'(bus.fifo_empty), 0);
            end
            busy_len = bus.busy ? busy_len + 1 : 0;
            if (busy_len == 3000) check("busy_watchdog", busy_len, 0);

            if (bus.frame_done) begin
                if (have_hi) finish_bit(1'b1);
                have_hi = 1'b0;
                check("frame_expected", int'(fexp.size() > 0), 1);
                if (fexp.size() > 0) begin
                    f = fexp.pop_front();
                    check("fifo_rd_count", rd_cnt, f.rd);
                    check("underrun", int'(bus.underrun), int'(f.und));
                    check("busy_at_done", int'(bus.busy), 0);
                end
            end

            if (bus.led_dout) begin
                if (!prev_d) begin
                    if (have_hi) begin
                        finish_bit(1'b0);
                    end else if (!quiet) begin
                        check("start_expected", int'(start_q.size() > 0), 1);
                        if (start_q.size() > 0) check("start_latency", cyc - start_q.pop_front(), 3);
                    end
                    have_hi = 1'b1;
                    hi      = 0;
                    lo      = 0;
                end
                hi++;
            end else if (have_hi) begin
                lo++;
            end
            prev_d = bus.led_dout;
            busy_q = bus.busy;

            if (done_req && !done_ack) begin
                check("bits_left", bexp.size(), 0);
                check("frames_left", fexp.size(), 0);
                check("starts_left", start_q.size(), 0);
                done_ack = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_fifo(input logic [11:0] w0, input logic [11:0] w1,
                             input logic [11:0] w2, input logic [11:0] w3, input int n);
        ld_w[0] = w0;
        ld_w[1] = w1;
        ld_w[2] = w2;
        ld_w[3] = w3;
        ld_n    = n;
        ld_gen++;
        tick(2);
    endtask

    task automatic exp_led(input logic [23:0] v);
        bit_exp_t e;
        for (int i = 23; i >= 0; i--) begin
            e.val = v[i];
            e.hi  = v[i] ? T1H : T0H;
            e.lo  = v[i] ? T1L : T0L;
            bexp.push_back(e);
        end
    endtask

    task automatic exp_frame(input int rd, input logic und);
        frame_exp_t f;
        f.rd  = rd;
        f.und = und;
        fexp.push_back(f);
    endtask

    task automatic pulse_start(input logic counted);
        bus.send_start = 1'b1;
        if (counted) start_q.push_back(cyc);
        tick(1);
        bus.send_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (bus.frame_done) break;
        end
    endtask

    initial begin
        bus.send_start = 1'b0;
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(2);

        // Two LEDs: red then blue.
        load_fifo(12'hF00, 12'h00F, 12'h000, 12'h000, 2);
        exp_led(24'h00FF00);
        exp_led(24'h0000FF);
        exp_frame(2, 1'b0);
        pulse_start(1'b1);
        wait_done(1000);
        tick(3);

        // Channel order and nibble replication.
        load_fifo(12'hA5C, 12'h3C1, 12'h000, 12'h000, 2);
        exp_led(24'h55AACC);
        exp_led(24'hCC3311);
        exp_frame(2, 1'b0);
        pulse_start(1'b1);
        wait_done(1000);
        tick(3);

        // Only one word available: second LED goes black, underrun sticks.
        load_fifo(12'h0F0, 12'h000, 12'h000, 12'h000, 1);
        exp_led(24'hFF0000);
        exp_led(24'h000000);
        exp_frame(1, 1'b1);
        pulse_start(1'b1);
        wait_done(1000);
        tick(3);

        // Repeated start while busy is ignored; a fresh start clears underrun.
        load_fifo(12'h123, 12'hFFF, 12'h000, 12'h000, 2);
        exp_led(24'h221133);
        exp_led(24'hFFFFFF);
        exp_frame(2, 1'b0);
        pulse_start(1'b1);
        tick(20);
        pulse_start(1'b0);
        tick(100);
        pulse_start(1'b0);
        wait_done(1000);
        tick(3);

        // Reset while bit 5 of LED0 is high aborts the frame.
        load_fifo(12'hF00, 12'h00F, 12'h000, 12'h000, 2);
        quiet = 1'b1;
        pulse_start(1'b0);
        tick(32);
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(2);
        quiet = 1'b0;

        load_fifo(12'h00F, 12'hF00, 12'h000, 12'h000, 2);
        exp_led(24'h0000FF);
        exp_led(24'h00FF00);
        exp_frame(2, 1'b0);
        pulse_start(1'b1);
        wait_done(1000);
        tick(3);

        // Back-to-back frames: restart in the cycle after frame_done.
        load_fifo(12'hF0F, 12'h0F0, 12'h5A5, 12'h111, 4);
        exp_led(24'h00FFFF);
        exp_led(24'hFF0000);
        exp_frame(2, 1'b0);
        exp_led(24'hAA5555);
        exp_led(24'h111111);
        exp_frame(2, 1'b0);
        pulse_start(1'b1);
        wait_done(1000);
        tick(1);
        pulse_start(1'b1);
        wait_done(1000);
        tick(5);

        done_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done_ack) break;
            tick(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/led_fifo_tx.md
LED_FIFO_TX -- requirements
Module: led_fifo_tx

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  LED_NUM  47  LEDs per frame (FIFO words consumed per frame)
  T0H  20  clocks high for a 0 bit
  T0L  43  clocks low for a 0 bit
  T1H  40  clocks high for a 1 bit
  T1L  23  clocks low for a 1 bit
  TRST  2500  clocks low latch gap after the last bit
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock
  rstn  in  1  asynchronous, active-low reset
  send_start  in  1  one-cycle request to transmit one frame
  fifo_empty  in  1  FIFO has no word
  fifo_rdata  in  12  {R[3:0],G[3:0],B[3:0]}, valid one cycle after fifo_rd
  fifo_rd  out  1  FIFO read strobe, one cycle per word
  led_dout  out  1  one-wire serial LED line
  busy  out  1  high from accepted start to end of latch gap
  frame_done  out  1  one-cycle pulse at end of frame
  underrun  out  1  sticky: FIFO empty when a word was required

Function
REQ-003 States: IDLE, FETCH, LOAD, BIT_H, BIT_L, LATCH; busy=1 in every state except IDLE.
REQ-004 IDLE: send_start=1 -> FETCH, led_cnt=0, underrun cleared; send_start outside IDLE is ignored.
REQ-005 FETCH (1 cycle): fifo_rd=!fifo_empty; if fifo_empty, pixel forced to 0 and underrun set; -> LOAD.
REQ-006 LOAD (1 cycle): shift register <= {R,R,G,G,B,B} expanded in GRB order, 24 bits: {G,G,R,R,B,B}, MSB first; bit_cnt=0; -> BIT_H.
REQ-007 Each 4-bit channel expands to 8 bits by replication (4'hA -> 8'hAA).
REQ-008 BIT_H: led_dout=1 for T1H (bit=1) or T0H (bit=0) cycles, then BIT_L: led_dout=0 for T1L/T0L cycles; bit period exactly TxH+TxL, no extra cycles.
REQ-009 Prefetch: in the first BIT_H cycle of bit 0 of LED n, if n+1<LED_NUM, issue fifo_rd (or flag underrun and prefetch 0 if fifo_empty); capture fifo_rdata next cycle into a 24-bit prefetch register.
REQ-010 At end of BIT_L of bit 23: if led_cnt+1<LED_NUM, load prefetch into shift register, led_cnt++, bit_cnt=0, -> BIT_H same edge (no gap between LEDs); else -> LATCH.
REQ-011 LATCH: led_dout=0 for TRST cycles, then frame_done=1 for one cycle, -> IDLE.
REQ-012 Exactly LED_NUM fifo_rd pulses per frame when FIFO never empty; fifo_rd never asserted while fifo_empty=1.
REQ-013 Underrun never stalls the line: the missing LED transmits 24'h000000 with normal timing.
REQ-014 led_dout=0 in IDLE, FETCH, LOAD, LATCH.
REQ-015 Timer wide enough for max(TRST, T0H+T0L, T1H+T1L); led_cnt width clog2(LED_NUM+1); bit_cnt 5 bits.
REQ-016 Latency: send_start at cycle 0 -> led_dout rises at cycle 3 (IDLE->FETCH->LOAD->BIT_H).

Reset
REQ-017 rstn=0 asynchronously forces IDLE and led_dout=0, fifo_rd=0, busy=0, frame_done=0, underrun=0, all counters and shift/prefetch registers 0.
REQ-018 Reset mid-frame aborts the frame; no latch gap is emitted; words already read are discarded.

Verification (LED_NUM=2, T0H=2, T0L=4, T1H=4, T1L=2, TRST=10)
REQ-019 FIFO holds 12'hF00, 12'h00F; pulse send_start -> LED0 bits = 24'h00FF00 (8x"0",8x"1",8x"0"), LED1 = 24'h0000FF; each bit 6 cycles; 2 fifo_rd pulses; 10 low cycles; frame_done one cycle; busy falls with return to IDLE.
REQ-020 FIFO holds 12'hA5C -> first byte on the line is 8'h55 (G), then 8'hAA (R), then 8'hCC (B).
REQ-021 FIFO holds one word only -> second LED transmits 24'h000000 at normal timing, underrun=1 after frame, fifo_rd asserted once; next send_start clears underrun.
REQ-022 send_start pulsed again while busy -> ignored; exactly one frame, 2 fifo_rd pulses.
REQ-023 rstn asserted during bit 5 of LED0 -> led_dout=0 immediately, busy=0, no frame_done; next send_start transmits full frame normally.
REQ-024 Back-to-back: send_start in the cycle after frame_done -> second frame starts with 3-cycle latency, total bit high/low durations unchanged.
